// File: rtl/regfile_pkg.sv
// Shared constants, types and state encoding for the 8x4 register file and its write arbiter.
package regfile_pkg;

  localparam int unsigned RF_ADDR_W = 3;
  localparam int unsigned RF_DATA_W = 4;
  localparam int unsigned NUM_REQ   = 2;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with next-pointer computation; purely combinational.
module rr_arbiter2 (
  input  logic       enable_i,
  input  logic       prio_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o,
  output logic       prio_o
);

  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      unique case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = prio_i ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
    end
    // Favour the other requester after a grant; grant to 0 sets pointer to 1 and vice versa.
    prio_o = (grant_o != 2'b00) ? grant_o[0] : prio_i;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter in front of the register file write port.
// Define REGFILE_ARB_CLEAR_EN to build in the zero-fill clear sequencer.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DATA_W = RF_DATA_W
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
  input  logic                            clear_req,
  output logic                            clear_busy,
  output logic                            clear_done,
  output logic                            rf_cs_n,
  output logic                            rf_w_en_n,
  output logic [ADDR_W-1:0]               rf_w_addr,
  output logic [DATA_W-1:0]               rf_w_data
);

  logic              arb_en;
  logic [1:0]        grant;
  logic              prio_q, prio_d;
  logic              accept;
  logic              sel;
  logic              clear_load;
  logic [ADDR_W-1:0] clr_addr;

  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

`ifdef REGFILE_ARB_CLEAR_EN
  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // The write for the counter value is loaded one cycle ahead so it shows on the pins
  // in the same cycle the counter holds that address.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clear_load = 1'b0;
    clr_addr   = '0;
    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d    = CLEAR;
          cnt_d      = '0;
          clear_load = 1'b1;
          clr_addr   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == '1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          clear_load = 1'b1;
          clr_addr   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign arb_en     = !reset && (state_q == IDLE) && !clear_req;
  assign clear_busy = (state_q == CLEAR);
  assign clear_done = (state_q == CLEAR) && (cnt_q == '1);
`else
  logic unused_clear_req;

  assign unused_clear_req = clear_req;
  assign clear_load       = 1'b0;
  assign clr_addr         = '0;
  assign arb_en           = !reset;
  assign clear_busy       = 1'b0;
  assign clear_done       = 1'b0;
`endif

  rr_arbiter2 u_rr_arbiter2 (
    .enable_i (arb_en),
    .prio_i   (prio_q),
    .valid_i  (req_valid),
    .grant_o  (grant),
    .prio_o   (prio_d)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign sel       = grant[1];

  always_comb begin
    wr_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (accept) begin
      wr_d   = 1'b1;
      addr_d = req_addr[sel];
      data_d = req_data[sel];
    end else if (clear_load) begin
      wr_d   = 1'b1;
      addr_d = clr_addr;
      data_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prio_q <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      prio_q <= prio_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign rf_cs_n   = ~wr_q;
  assign rf_w_en_n = ~wr_q;
  assign rf_w_addr = addr_q;
  assign rf_w_data = data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter with a behavioural 8x4 register file behind it.
module tb_regfile_write_arbiter;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      req_valid = 2'b00;
  logic [1:0]      req_ready;
  logic [1:0][2:0] req_addr = '0;
  logic [1:0][3:0] req_data = '0;
  logic            clear_req = 1'b0;
  logic            clear_busy;
  logic            clear_done;
  logic            rf_cs_n;
  logic            rf_w_en_n;
  logic [2:0]      rf_w_addr;
  logic [3:0]      rf_w_data;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [6:0]  sb[$];
  logic [1:0]  exp_ready;
  logic        m_prio = 1'b0;
  logic [3:0]  rf_mem [8];

  regfile_write_arbiter #(
    .ADDR_W (3),
    .DATA_W (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .rf_cs_n    (rf_cs_n),
    .rf_w_en_n  (rf_w_en_n),
    .rf_w_addr  (rf_w_addr),
    .rf_w_data  (rf_w_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rf_cs_n === 1'b0 && rf_w_en_n === 1'b0) rf_mem[rf_w_addr] <= rf_w_data;
  end

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clock) begin
    logic [6:0] w;
    if (!reset && (rf_cs_n === 1'b0 || rf_w_en_n === 1'b0)) begin
      n_cmp++;
      if (rf_cs_n !== rf_w_en_n) begin
        n_err++;
        $display("FAIL wr_strobe: cs_n=%b w_en_n=%b, want both low", rf_cs_n, rf_w_en_n);
      end else if (sb.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: got addr=%0h data=%0h, want no write", rf_w_addr, rf_w_data);
      end else begin
        w = sb.pop_front();
        if ({rf_w_addr, rf_w_data} !== w) begin
          n_err++;
          $display("FAIL wr_pop: got addr=%0h data=%0h, want addr=%0h data=%0h",
                   rf_w_addr, rf_w_data, w[6:4], w[3:0]);
        end
      end
    end
  end

  function automatic logic [1:0] model_grant(input logic [1:0] v, input logic p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  // Drives one cycle of stimulus and records the expected handshake and write.
  task automatic drive(input logic [1:0] v, input logic [2:0] a0, input logic [3:0] d0,
                       input logic [2:0] a1, input logic [3:0] d1, input logic clr,
                       input logic blocked);
    @(posedge clock);
    #1;
    req_valid   = v;
    req_addr[0] = a0;
    req_data[0] = d0;
    req_addr[1] = a1;
    req_data[1] = d1;
    clear_req   = clr;
    exp_ready   = blocked ? 2'b00 : model_grant(v, m_prio);
    if (exp_ready[0]) sb.push_back({a0, d0});
    else if (exp_ready[1]) sb.push_back({a1, d1});
    if (exp_ready != 2'b00) m_prio = exp_ready[0];
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #1;
    reset     = 1'b1;
    req_valid = 2'b00;
    clear_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset  = 1'b0;
    m_prio = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 2'b11;
    repeat (2) @(posedge clock);
    #2;
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_err++;
      $display("FAIL reset_ready: got %b, want 00", req_ready);
    end
    n_cmp++;
    if (rf_cs_n !== 1'b1 || rf_w_en_n !== 1'b1) begin
      n_err++;
      $display("FAIL reset_strobe: cs_n=%b w_en_n=%b, want 1 1", rf_cs_n, rf_w_en_n);
    end
    n_cmp++;
    if (rf_w_addr !== 3'd0 || rf_w_data !== 4'd0) begin
      n_err++;
      $display("FAIL reset_addr_data: got %0h/%0h, want 0/0", rf_w_addr, rf_w_data);
    end
    n_cmp++;
    if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_clear: busy=%b done=%b, want 0 0", clear_busy, clear_done);
    end
    @(posedge clock);
    #1;
    reset     = 1'b0;
    req_valid = 2'b00;
    m_prio    = 1'b0;
    @(posedge clock);
    #2;
    n_cmp++;
    if (rf_cs_n !== 1'b1 || req_ready !== 2'b00) begin
      n_err++;
      $display("FAIL idle_after_reset: cs_n=%b ready=%b, want 1 00", rf_cs_n, req_ready);
    end
  endtask

  task automatic test_single();
    drive(2'b01, 3'd3, 4'hA, 3'd0, 4'h0, 1'b0, 1'b0);
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL single_ready: got %b, want 01", req_ready);
    end
    drive(2'b00, 3'd0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0);
    n_cmp++;
    if (rf_cs_n !== 1'b0 || rf_w_en_n !== 1'b0 || rf_w_addr !== 3'd3 || rf_w_data !== 4'hA) begin
      n_err++;
      $display("FAIL single_write: cs_n=%b we_n=%b addr=%0h data=%0h, want 0 0 3 a",
               rf_cs_n, rf_w_en_n, rf_w_addr, rf_w_data);
    end
    drive(2'b00, 3'd0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0);
    n_cmp++;
    if (rf_mem[3] !== 4'hA) begin
      n_err++;
      $display("FAIL single_readback: got %0h, want a", rf_mem[3]);
    end
    n_cmp++;
    if (rf_cs_n !== 1'b1 || rf_w_addr !== 3'd3 || rf_w_data !== 4'hA) begin
      n_err++;
      $display("FAIL single_hold: cs_n=%b addr=%0h data=%0h, want 1 3 a",
               rf_cs_n, rf_w_addr, rf_w_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 3'(i), 4'(i + 1), 3'(i + 4), 4'(i + 8), 1'b0, 1'b0);
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++;
      if (req_ready !== want) begin
        n_err++;
        $display("FAIL b2b_grant[%0d]: got %b, want %b", i, req_ready, want);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 3'd5, 4'h1, 3'd5, 4'h2, 1'b0, 1'b0);
      n_cmp++;
      if (req_ready !== exp_ready) begin
        n_err++;
        $display("FAIL same_addr_grant[%0d]: got %b, want %b", i, req_ready, exp_ready);
      end
    end
    drive(2'b00, 3'd0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0);
    drive(2'b00, 3'd0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0);
    n_cmp++;
    if (rf_mem[5] !== 4'h2) begin
      n_err++;
      $display("FAIL same_addr_last_wins: got %0h, want 2", rf_mem[5]);
    end
  endtask

`ifdef REGFILE_ARB_CLEAR_EN
  task automatic test_clear();
    drive(2'b10, 3'd0, 4'h0, 3'd6, 4'h9, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) sb.push_back({3'(k), 4'h0});
    n_cmp++;
    if (req_ready !== 2'b00 || clear_busy !== 1'b0) begin
      n_err++;
      $display("FAIL clear_start: ready=%b busy=%b, want 00 0", req_ready, clear_busy);
    end
    for (int k = 0; k < 8; k++) begin
      drive(2'b10, 3'd0, 4'h0, 3'd6, 4'h9, 1'b0, 1'b1);
      n_cmp++;
      if (req_ready !== 2'b00 || clear_busy !== 1'b1 || clear_done !== (k == 7) ||
          rf_cs_n !== 1'b0 || rf_w_addr !== 3'(k) || rf_w_data !== 4'h0) begin
        n_err++;
        $display("FAIL clear_cycle[%0d]: ready=%b busy=%b done=%b cs_n=%b addr=%0h data=%0h",
                 k, req_ready, clear_busy, clear_done, rf_cs_n, rf_w_addr, rf_w_data);
      end
    end
    drive(2'b10, 3'd0, 4'h0, 3'd6, 4'h9, 1'b0, 1'b0);
    n_cmp++;
    if (req_ready !== 2'b10 || clear_busy !== 1'b0 || clear_done !== 1'b0) begin
      n_err++;
      $display("FAIL clear_release: ready=%b busy=%b done=%b, want 10 0 0",
               req_ready, clear_busy, clear_done);
    end
    drive(2'b00, 3'd0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0);
    drive(2'b00, 3'd0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (rf_mem[k] !== ((k == 6) ? 4'h9 : 4'h0)) begin
        n_err++;
        $display("FAIL clear_mem[%0d]: got %0h, want %0h", k, rf_mem[k], (k == 6) ? 4'h9 : 4'h0);
      end
    end
  endtask

  task automatic test_clear_reset();
    drive(2'b00, 3'd0, 4'h0, 3'd0, 4'h0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) sb.push_back({3'(k), 4'h0});
    for (int k = 0; k < 3; k++) drive(2'b00, 3'd0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++;
    if (req_ready !== 2'b00 || rf_cs_n !== 1'b1 || rf_w_en_n !== 1'b1 || rf_w_addr !== 3'd0 ||
        rf_w_data !== 4'd0 || clear_busy !== 1'b0 || clear_done !== 1'b0) begin
      n_err++;
      $display("FAIL clear_abort: ready=%b cs_n=%b we_n=%b addr=%0h data=%0h busy=%b done=%b",
               req_ready, rf_cs_n, rf_w_en_n, rf_w_addr, rf_w_data, clear_busy, clear_done);
    end
    sb.delete();
    m_prio = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive(2'b00, 3'd0, 4'h0, 3'd0, 4'h0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) sb.push_back({3'(k), 4'h0});
    drive(2'b00, 3'd0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b1);
    n_cmp++;
    if (rf_cs_n !== 1'b0 || rf_w_addr !== 3'd0 || clear_busy !== 1'b1) begin
      n_err++;
      $display("FAIL clear_restart: cs_n=%b addr=%0h busy=%b, want 0 0 1",
               rf_cs_n, rf_w_addr, clear_busy);
    end
    for (int k = 1; k < 8; k++) drive(2'b00, 3'd0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b1);
    drive(2'b00, 3'd0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0);
    drive(2'b00, 3'd0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0);
  endtask
`else
  task automatic test_no_clear();
    drive(2'b01, 3'd2, 4'h7, 3'd0, 4'h0, 1'b1, 1'b0);
    n_cmp++;
    if (req_ready !== 2'b01 || clear_busy !== 1'b0 || clear_done !== 1'b0) begin
      n_err++;
      $display("FAIL noclear_grant0: ready=%b busy=%b done=%b, want 01 0 0",
               req_ready, clear_busy, clear_done);
    end
    drive(2'b11, 3'd4, 4'h3, 3'd5, 4'h5, 1'b1, 1'b0);
    n_cmp++;
    if (req_ready !== exp_ready || clear_busy !== 1'b0) begin
      n_err++;
      $display("FAIL noclear_grant1: ready=%b busy=%b, want %b 0", req_ready, clear_busy, exp_ready);
    end
    drive(2'b00, 3'd0, 4'h0, 3'd0, 4'h0, 1'b1, 1'b0);
    n_cmp++;
    if (rf_cs_n !== 1'b0 || clear_busy !== 1'b0 || clear_done !== 1'b0) begin
      n_err++;
      $display("FAIL noclear_write: cs_n=%b busy=%b done=%b, want 0 0 0",
               rf_cs_n, clear_busy, clear_done);
    end
    drive(2'b00, 3'd0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0);
    drive(2'b00, 3'd0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0);
    n_cmp++;
    if (rf_mem[2] !== 4'h7) begin
      n_err++;
      $display("FAIL noclear_mem: got %0h, want 7", rf_mem[2]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
`ifdef REGFILE_ARB_CLEAR_EN
    test_clear();
    test_clear_reset();
`else
    test_no_clear();
`endif
    drive(2'b00, 3'd0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0);
    drive(2'b00, 3'd0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d writes outstanding, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
